// File: rtl/apb_arb_pkg.sv
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types for the APB request arbiter: FSM states, the
//               command record and the timeout-timer sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_arb_pkg;

    // Width of the reference command record, matching the default bus widths.
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                    write;
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W/8-1:0] strobe;
    } arb_cmd_t;

    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_req_arbiter_if.sv
// ============================================================================
// Module      : apb_req_arbiter_if
// Description : Requester command/response bundle plus the APB master bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_req_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*STRB_WIDTH-1:0] req_strobe;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [ADDR_WIDTH-1:0]         paddr;
    logic [DATA_WIDTH-1:0]         pwdata;
    logic [STRB_WIDTH-1:0]         pstrb;
    logic                          pready;
    logic                          pslverr;
    logic [DATA_WIDTH-1:0]         prdata;

    // Arbiter side: serves the requesters and masters the APB bus.
    modport master (
        input  req, req_write, req_addr, req_wdata, req_strobe,
        output gnt, done, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    // Environment side: requesters plus the APB slave.
    modport slave (
        output req, req_write, req_addr, req_wdata, req_strobe,
        input  gnt, done, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, pslverr, prdata
    );

endinterface

`default_nettype wire

// File: rtl/apb_req_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector; the search starts just
//               after the previously granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [IDX_W-1:0]   last_gnt_i,
    output logic                    valid_o,
    output logic [NUM_REQ-1:0]      onehot_o,
    output logic [IDX_W-1:0]        idx_o
);

    always_comb begin
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(last_gnt_i) + k) % NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = IDX_W'(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_req_arbiter.sv
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin arbiter sequencing NUM_REQ requesters onto one
//               APB slave, with an ACCESS-phase timeout guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    apb_req_arbiter_if.master  bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int TMR_W      = timer_width(TIMEOUT);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;

    logic                    w_valid;
    logic [NUM_REQ-1:0]      w_onehot;
    logic [IDX_W-1:0]        w_idx;
    logic [TMR_W-1:0]        w_timer_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i      (bus.req),
        .last_gnt_i (last_gnt_q),
        .valid_o    (w_valid),
        .onehot_o   (w_onehot),
        .idx_o      (w_idx)
    );

    assign w_timer_inc = timer_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        gnt_d      = '0;
        done_d     = '0;
        rdata_d    = '0;
        err_d      = 1'b0;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;

        case (state_q)
            ST_IDLE: begin
                // A pending done marks the completion cycle, which never arbitrates.
                if (w_valid && (done_q == '0)) begin
                    state_d    = ST_SETUP;
                    last_gnt_d = w_idx;
                    idx_d      = w_idx;
                    timer_d    = '0;
                    gnt_d      = w_onehot;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    pwrite_d   = bus.req_write[w_idx];
                    paddr_d    = bus.req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d   = bus.req_write[w_idx] ?
                                 bus.req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
                    pstrb_d    = bus.req_strobe[w_idx*STRB_WIDTH +: STRB_WIDTH];
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (bus.pready || ((TIMEOUT != 0) && (w_timer_inc == TMR_W'(TIMEOUT)))) begin
                    state_d       = ST_IDLE;
                    done_d[idx_q] = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwrite_d      = 1'b0;
                    paddr_d       = '0;
                    pwdata_d      = '0;
                    pstrb_d       = '0;
                    // pready on the timeout edge still completes normally.
                    err_d         = bus.pready ? bus.pslverr : 1'b1;
                    rdata_d       = (bus.pready && !pwrite_q && !bus.pslverr) ?
                                    bus.prdata : '0;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
            idx_q      <= '0;
            timer_q    <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Self-checking bench for apb_req_arbiter against a transaction
//               level round-robin / APB timing model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_req_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a ();
    apb_req_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b ();

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) u_dut_nt (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    int       checks = 0;
    int       errors = 0;
    int       model_last;
    arb_cmd_t cmd [N];

    function automatic int model_pick(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (model_last + k) % N;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_cmd(input int i);
        cmd[i].write  = 1'($urandom % 2);
        cmd[i].addr   = $urandom;
        cmd[i].wdata  = $urandom;
        cmd[i].strobe = SW'($urandom);
    endtask

    task automatic drive_req(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            a.req_write[i]            = cmd[i].write;
            a.req_addr[i*AW +: AW]    = cmd[i].addr;
            a.req_wdata[i*DW +: DW]   = cmd[i].wdata;
            a.req_strobe[i*SW +: SW]  = cmd[i].strobe;
        end
        a.req = m;
    endtask

    // One full transfer starting in an arbitrating IDLE cycle; d = ACCESS cycles
    // with pready low before it rises (d >= TMO never raises it).
    task automatic run_txn(input logic [N-1:0] m, input int d, input bit slv,
                           input logic [DW-1:0] prd);
        int w, n;
        bit tmo;
        logic exp_err, wr;
        logic [DW-1:0] exp_rd, wd;
        logic [AW-1:0] ad;
        logic [SW-1:0] st;
        w  = model_pick(m);
        model_last = w;
        wr = cmd[w].write;
        ad = cmd[w].addr;
        wd = wr ? cmd[w].wdata : '0;
        st = cmd[w].strobe;
        tmo     = (d >= TMO);
        n       = tmo ? TMO : d + 1;
        exp_err = tmo ? 1'b1 : slv;
        exp_rd  = (tmo || wr || slv) ? '0 : prd;

        drive_req(m);
        a.pready = 1'b0;
        @(negedge clk);
        checks++;
        if (a.gnt !== 2'(1 << w)) begin
            errors++;
            $display("FAIL gnt got %b exp %b", a.gnt, 2'(1 << w));
        end
        checks++;
        if ({a.psel, a.penable, a.pwrite, a.done} !== {1'b1, 1'b0, wr, 2'b00}) begin
            errors++;
            $display("FAIL setup_ctrl got %b exp %b", {a.psel, a.penable, a.pwrite, a.done}, {1'b1, 1'b0, wr, 2'b00});
        end
        checks++;
        if ({a.paddr, a.pwdata, a.pstrb} !== {ad, wd, st}) begin
            errors++;
            $display("FAIL setup_bus got %h exp %h", {a.paddr, a.pwdata, a.pstrb}, {ad, wd, st});
        end
        a.req = '0;

        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            checks++;
            if ({a.gnt, a.done, a.psel, a.penable, a.pwrite, a.paddr, a.pwdata, a.pstrb} !==
                {2'b00, 2'b00, 1'b1, 1'b1, wr, ad, wd, st}) begin
                errors++;
                $display("FAIL access[%0d] got %h exp %h", j,
                         {a.gnt, a.done, a.psel, a.penable, a.pwrite, a.paddr, a.pwdata, a.pstrb},
                         {2'b00, 2'b00, 1'b1, 1'b1, wr, ad, wd, st});
            end
            a.pready  = (j == d);
            a.pslverr = slv;
            a.prdata  = prd;
        end

        @(negedge clk);
        checks++;
        if (a.done !== 2'(1 << w)) begin
            errors++;
            $display("FAIL done got %b exp %b", a.done, 2'(1 << w));
        end
        checks++;
        if ({a.rsp_err, a.rsp_rdata} !== {exp_err, exp_rd}) begin
            errors++;
            $display("FAIL rsp got %h exp %h", {a.rsp_err, a.rsp_rdata}, {exp_err, exp_rd});
        end
        checks++;
        if ({a.psel, a.penable, a.pwrite, a.paddr, a.pwdata, a.pstrb, a.gnt} !== '0) begin
            errors++;
            $display("FAIL bus_release got %h exp 0", {a.psel, a.penable, a.pwrite, a.paddr, a.pwdata, a.pstrb, a.gnt});
        end
        a.pready  = 1'b0;
        a.pslverr = 1'b0;
        a.prdata  = '0;
        @(negedge clk);
        checks++;
        if ({a.done, a.rsp_err, a.rsp_rdata, a.gnt, a.psel} !== '0) begin
            errors++;
            $display("FAIL post_done got %h exp 0", {a.done, a.rsp_err, a.rsp_rdata, a.gnt, a.psel});
        end
    endtask

    task automatic test_reset();
        a.req = '0; a.pready = 1'b0; a.pslverr = 1'b0; a.prdata = '0;
        a.req_write = '0; a.req_addr = '0; a.req_wdata = '0; a.req_strobe = '0;
        b.req = '0; b.pready = 1'b0; b.pslverr = 1'b0; b.prdata = '0;
        b.req_write = '0; b.req_addr = '0; b.req_wdata = '0; b.req_strobe = '0;
        model_last = N - 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({a.gnt, a.done, a.rsp_err, a.rsp_rdata, a.psel, a.penable, a.pwrite, a.paddr, a.pwdata, a.pstrb} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0",
                     {a.gnt, a.done, a.rsp_err, a.rsp_rdata, a.psel, a.penable, a.pwrite, a.paddr, a.pwdata, a.pstrb});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a.gnt, a.done, a.psel, a.penable, b.gnt, b.psel} !== '0) begin
            errors++;
            $display("FAIL idle_quiet got %h exp 0", {a.gnt, a.done, a.psel, a.penable, b.gnt, b.psel});
        end
    endtask

    task automatic test_back_to_back();
        int ngnt = 0, ndone = 0, last_cyc = 0;
        logic [N-1:0] exp_done [$];
        rand_cmd(0);
        rand_cmd(1);
        drive_req(2'b11);
        a.pready = 1'b1;
        for (int cyc = 1; cyc <= 40 && ndone < 4; cyc++) begin
            @(negedge clk);
            if (a.gnt !== '0) begin
                int w;
                w = model_pick(2'b11);
                model_last = w;
                checks++;
                if (a.gnt !== 2'(1 << w)) begin
                    errors++;
                    $display("FAIL b2b_gnt got %b exp %b", a.gnt, 2'(1 << w));
                end
                if (ngnt > 0) begin
                    checks++;
                    if (cyc - last_cyc != 4) begin
                        errors++;
                        $display("FAIL b2b_gap got %0d exp 4", cyc - last_cyc);
                    end
                end
                exp_done.push_back(2'(1 << w));
                last_cyc = cyc;
                ngnt++;
                if (ngnt == 4) a.req = '0;
            end
            if (a.done !== '0) begin
                checks++;
                if (exp_done.size() == 0 || a.done !== exp_done[0]) begin
                    errors++;
                    $display("FAIL b2b_done got %b exp %b", a.done, (exp_done.size() > 0) ? exp_done[0] : 2'b00);
                end
                if (exp_done.size() > 0) void'(exp_done.pop_front());
                ndone++;
            end
        end
        checks++;
        if (ndone != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 4", ndone);
        end
        a.pready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        cmd[0] = '{write: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, strobe: 4'hF};
        rand_cmd(1);
        run_txn(2'b01, 0, 1'b0, 32'h1234_5678);
    endtask

    task automatic test_read_wait();
        rand_cmd(0);
        cmd[1] = '{write: 1'b0, addr: 32'h20, wdata: 32'h5555_5555, strobe: 4'hF};
        run_txn(2'b10, 2, 1'b0, 32'hA5A5_A5A5);
    endtask

    task automatic test_slverr();
        cmd[0] = '{write: 1'b1, addr: 32'h44, wdata: 32'h0BAD_F00D, strobe: 4'h3};
        run_txn(2'b01, 1, 1'b1, 32'hFFFF_0000);
        cmd[1] = '{write: 1'b0, addr: 32'h48, wdata: 32'h0, strobe: 4'hF};
        run_txn(2'b10, 0, 1'b1, 32'h7777_7777);
    endtask

    task automatic test_timeout();
        bit stuck_ok = 1'b1;
        cmd[0] = '{write: 1'b0, addr: 32'h80, wdata: 32'h0, strobe: 4'hF};
        run_txn(2'b01, TMO + 3, 1'b0, 32'hCAFE_CAFE);
        cmd[1] = '{write: 1'b0, addr: 32'h84, wdata: 32'h0, strobe: 4'hF};
        run_txn(2'b11, 0, 1'b0, 32'h1357_9BDF);
        // Same edge: pready arrives on the cycle the timer would expire.
        run_txn(2'b01, TMO - 1, 1'b0, 32'h2468_ACE0);

        b.req_write = 2'b01; b.req_addr = {32'h0, 32'h90};
        b.req_wdata = {32'h0, 32'h1111_2222}; b.req_strobe = 8'h0F;
        b.req = 2'b01;
        @(negedge clk);
        checks++;
        if (b.gnt !== 2'b01) begin
            errors++;
            $display("FAIL nt_gnt got %b exp 01", b.gnt);
        end
        b.req = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!(b.psel === 1'b1 && b.penable === 1'b1 && b.done === 2'b00)) stuck_ok = 1'b0;
        end
        checks++;
        if (stuck_ok !== 1'b1) begin
            errors++;
            $display("FAIL nt_hold got %b exp 1", stuck_ok);
        end
        b.pready = 1'b1;
        @(negedge clk);
        checks++;
        if ({b.done, b.rsp_err, b.psel} !== {2'b01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nt_done got %b exp 01_0_0", {b.done, b.rsp_err, b.psel});
        end
        b.pready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rand_cmd(0);
        drive_req(2'b01);
        a.pready = 1'b0;
        repeat (2) @(negedge clk);
        a.req = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a.gnt, a.done, a.rsp_err, a.rsp_rdata, a.psel, a.penable, a.pwrite, a.paddr, a.pwdata, a.pstrb} !== '0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0",
                     {a.gnt, a.done, a.rsp_err, a.rsp_rdata, a.psel, a.penable, a.pwrite, a.paddr, a.pwdata, a.pstrb});
        end
        a.pready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
        @(negedge clk);
        checks++;
        if ({a.done, a.psel} !== '0) begin
            errors++;
            $display("FAIL reset_no_done got %b exp 0", {a.done, a.psel});
        end
        a.pready = 1'b0;
        rand_cmd(0);
        rand_cmd(1);
        run_txn(2'b11, int'($urandom_range(0, 2)), 1'b0, $urandom);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [N-1:0] m;
            m = 2'($urandom_range(1, 3));
            rand_cmd(0);
            rand_cmd(1);
            run_txn(m, int'($urandom_range(0, TMO + 1)), ($urandom % 4) == 0, $urandom);
            if ($urandom % 3 == 0) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if ($time > 0 && $isunknown(errors)) errors = 0;
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Round-robin arbiter and APB master sequencer that shares one APB slave port (and the memory behind it) between NUM_REQ requesters. It latches one requester's command, drives the APB SETUP/ACCESS phases, and waits for pready with a timeout guard. It then returns rdata and error status to the granted requester. It sits upstream of the bridge's APB slave / memory path.

Parameters:
NUM_REQ, 2, number of requesters (≥2)
ADDR_WIDTH, 32, paddr / req_addr width
DATA_WIDTH, 32, pwdata / prdata width; strobe width = DATA_WIDTH/8
TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  per-requester request level
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_strobe  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: command latched
done  out  NUM_REQ  one-hot, 1-cycle pulse: transfer finished
rsp_rdata  out  DATA_WIDTH  read data, valid with done
rsp_err  out  1  slverr or timeout, valid with done
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pready  in  1  APB ready
pslverr  in  1  APB slave error
prdata  in  DATA_WIDTH  APB read data

Behaviour:
- All outputs are registered. Reset values: every output 0, state IDLE, last_gnt = NUM_REQ-1, timer 0. Reset mid-transfer aborts immediately with no done pulse.
- States: IDLE, SETUP, ACCESS.
- IDLE, cycle T, any req high:
  - Winner is the first asserted req searching from last_gnt+1, modulo NUM_REQ.
  - Latch winner's write/addr/wdata/strobe and update last_gnt.
  - At T+1: gnt[winner]=1, state SETUP, psel=1, penable=0, paddr/pwrite/pwdata/pstrb = latched values (pwdata=0 for reads).
- SETUP -> ACCESS unconditionally. At T+2: psel=1, penable=1. APB address/control are stable through SETUP and ACCESS.
- ACCESS, pready=1 sampled:
  - Next cycle: psel=penable=0, all p* outputs 0, state IDLE.
  - done[winner]=1, rsp_err=pslverr.
  - rsp_rdata=prdata for a read with pslverr=0, else 0.
- ACCESS, pready=0: timer increments.
  - If TIMEOUT≠0 and timer reaches TIMEOUT, abort: next cycle psel=penable=0, done[winner]=1, rsp_err=1, rsp_rdata=0, state IDLE.
  - pready on the same edge as the timeout wins: normal completion.
- Timer clears on entry to SETUP. Width is clog2(TIMEOUT+1), min 1.
- rsp_rdata/rsp_err are 0 in every cycle where done=0.
- Minimum cost: 4 cycles per transfer (IDLE arbitration, SETUP, ACCESS, completion cycle back in IDLE). No back-to-back ACCESS->SETUP.
- Requester protocol:
  - Command inputs must be stable while req is high and until gnt.
  - req still high in the IDLE cycle after done counts as a new request.
  - req changes outside IDLE are ignored.
- Requests only sample in IDLE. A req withdrawn before IDLE is never granted.
- No requests in IDLE: stay IDLE, outputs 0.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE, SETUP, ACCESS), a command struct (write, addr, wdata, strobe), and a clog2-based timer width function.
- Sub-module rr_pick: combinational round-robin selector. Inputs req vector and last_gnt; outputs valid and one-hot/index winner. The top holds the last_gnt register.

Test Plan:
1. NUM_REQ=2, pready tied 1. req0 write addr 0x10, wdata 0xDEADBEEF, strb 0xF, req rises at T -> gnt0 at T+1, psel T+1..T+2, penable T+2, done0 at T+3 with rsp_err=0, rsp_rdata=0, pwdata=0xDEADBEEF during phases.
2. After reset, req0 and req1 held high continuously -> grants alternate 0,1,0,1; each gnt is 4 cycles after the previous one.
3. req1 read addr 0x20, pready low 2 ACCESS cycles then high with prdata 0xA5A5A5A5 -> done1 at T+5, rsp_rdata=0xA5A5A5A5, rsp_err=0.
4. Write with pslverr=1 at pready -> done pulse with rsp_err=1, rsp_rdata=0.
5. TIMEOUT=4, pready held low -> abort after 4 ACCESS cycles: done with rsp_err=1, psel falls the same cycle, next req granted normally. Separately, TIMEOUT=0 holds in ACCESS indefinitely.
6. Assert rst mid-ACCESS -> all outputs 0 immediately, no done. After release, req0 and req1 both high -> req0 granted first.
